// File: rtl/if1_fetch_gen.sv
// IF1 fetch-address generator: holds the fetch PC, issues aligned
// fetch requests, and tags returning responses with their PC.
module if1_fetch_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000,
  parameter int FETCH_BYTES = 8,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              bp_taken,
  input  logic [ADDR_W-1:0] bp_target,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              busy_full
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int DEPTH = 1 << PW;
  localparam logic [ADDR_W-1:0] FB = ADDR_W'(FETCH_BYTES);
  localparam logic [CW-1:0] MAXI = CW'(MAX_INFLIGHT);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_seq;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     inflight_d;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     drop_d;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic              kill;
  logic              accept;
  logic              drop_now;

  assign kill      = flush | br_redirect;
  assign busy_full = (inflight == MAXI);
  assign req_valid = (state == RUN) & ~pause & ~kill & ~busy_full;
  assign accept    = req_valid & req_ready;
  assign req_addr  = pc_q;
  assign fetch_pc  = tag_mem[rd_ptr];
  assign drop_now  = rsp_valid & (drop_cnt != '0);
  assign fetch_valid = rsp_valid & (drop_cnt == '0) & ~kill;
  assign pc_seq    = (pc_q & ~(FB - 1'b1)) + FB;

  // Next-PC selection: flush beats redirect beats prediction beats sequential.
  always_comb begin
    pc_d = pc_q;
    if (flush)
      pc_d = flush_pc;
    else if (br_redirect)
      pc_d = br_target;
    else if (accept && bp_taken)
      pc_d = bp_target;
    else if (accept)
      pc_d = pc_seq;
  end

  // Outstanding and to-be-dropped response counts.
  // A kill marks every response still in flight after this cycle as stale,
  // so the drop count is the remaining outstanding count, never more.
  always_comb begin
    inflight_d = inflight + CW'(accept) - CW'(rsp_valid);
    drop_d     = drop_cnt - CW'(drop_now);
    if (kill)
      drop_d = inflight - CW'(rsp_valid);
  end

  // State, PC, counters and the PC tag FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++)
        tag_mem[i] <= '0;
    end else begin
      state    <= RUN;
      pc_q     <= pc_d;
      inflight <= inflight_d;
      drop_cnt <= drop_d;
      if (accept) begin
        tag_mem[wr_ptr] <= pc_q;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rsp_valid)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A response with nothing outstanding means the cache and IF1 disagree.
  always_ff @(posedge clk) begin
    if (!rst && rsp_valid)
      assert (inflight != '0);
  end

endmodule

// File: tb/tb_if1_fetch_gen.sv
// Directed testbench for if1_fetch_gen.
// Linear stimulus with immediate-assertion checks.
module tb_if1_fetch_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        busy_full;

  int checks = 0;
  int errors = 0;

  if1_fetch_gen dut (
    .clk(clk),
    .rst(rst),
    .pause(pause),
    .flush(flush),
    .flush_pc(flush_pc),
    .br_redirect(br_redirect),
    .br_target(br_target),
    .bp_taken(bp_taken),
    .bp_target(bp_target),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .busy_full(busy_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    br_redirect = 1'b0;
    br_target = '0;
    bp_taken = 1'b0;
    bp_target = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    #2;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_busy_full", 32'(busy_full), 32'd0);
    chk("rst_req_addr", req_addr, 32'hBFC00000);

    // T1: BOOT one cycle, then sequential fetch
    tick();
    rst = 1'b0;
    req_ready = 1'b1;
    #1;
    chk("boot_req_valid", 32'(req_valid), 32'd0);
    tick();
    chk("t1_req_valid0", 32'(req_valid), 32'd1);
    chk("t1_addr0", req_addr, 32'hBFC00000);
    tick();
    chk("t1_addr1", req_addr, 32'hBFC00008);
    rsp_valid = 1'b1;
    #1;
    chk("t1_fetch_valid0", 32'(fetch_valid), 32'd1);
    chk("t1_fetch_pc0", fetch_pc, 32'hBFC00000);
    tick();
    chk("t1_addr2", req_addr, 32'hBFC00010);
    rsp_valid = 1'b0;
    tick();

    // T2: two outstanding -> full, PC held, one rsp resumes issue
    chk("t2_busy_full", 32'(busy_full), 32'd1);
    chk("t2_req_valid", 32'(req_valid), 32'd0);
    chk("t2_addr", req_addr, 32'hBFC00018);
    tick();
    chk("t2_addr_held", req_addr, 32'hBFC00018);
    rsp_valid = 1'b1;
    #1;
    chk("t2_fetch_valid", 32'(fetch_valid), 32'd1);
    chk("t2_fetch_pc", fetch_pc, 32'hBFC00008);
    tick();
    rsp_valid = 1'b0;
    #1;
    chk("t2_not_full", 32'(busy_full), 32'd0);
    chk("t2_resume", 32'(req_valid), 32'd1);

    // T3: predicted taken, then aligned sequential increment
    bp_taken = 1'b1;
    bp_target = 32'h80001234;
    tick();
    bp_taken = 1'b0;
    chk("t3_addr_tgt", req_addr, 32'h80001234);
    chk("t3_full", 32'(busy_full), 32'd1);
    rsp_valid = 1'b1;
    #1;
    chk("t3_fpc0", fetch_pc, 32'hBFC00010);
    tick();
    chk("t3_fpc1", fetch_pc, 32'hBFC00018);
    tick();
    chk("t3_addr_al", req_addr, 32'h80001238);
    chk("t3_fpc2", fetch_pc, 32'h80001234);
    tick();
    chk("t3_addr_seq", req_addr, 32'h80001240);
    rsp_valid = 1'b0;
    tick();

    // T4: redirect with two outstanding, both responses dropped
    chk("t4_full", 32'(busy_full), 32'd1);
    br_redirect = 1'b1;
    br_target = 32'h90000000;
    #1;
    chk("t4_rv_kill", 32'(req_valid), 32'd0);
    tick();
    br_redirect = 1'b0;
    chk("t4_addr", req_addr, 32'h90000000);
    rsp_valid = 1'b1;
    #1;
    chk("t4_drop0", 32'(fetch_valid), 32'd0);
    tick();
    chk("t4_drop1", 32'(fetch_valid), 32'd0);
    tick();
    req_ready = 1'b0;
    #1;
    chk("t4_fv_new", 32'(fetch_valid), 32'd1);
    chk("t4_fpc_new", fetch_pc, 32'h90000000);
    tick();
    rsp_valid = 1'b0;
    req_ready = 1'b1;
    #1;

    // T5: pause holds issue, outstanding response still forwarded
    chk("t5_addr", req_addr, 32'h90000008);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_pause_rv", 32'(req_valid), 32'd0);
      if (i == 2) begin
        rsp_valid = 1'b1;
        #1;
        chk("t5_pause_fv", 32'(fetch_valid), 32'd1);
        chk("t5_pause_fpc", fetch_pc, 32'h90000008);
      end
      tick();
      rsp_valid = 1'b0;
    end
    pause = 1'b0;
    chk("t5_pause_pc", req_addr, 32'h90000010);
    flush = 1'b1;
    flush_pc = 32'hFFFFFFF8;
    br_redirect = 1'b1;
    br_target = 32'h12345678;
    tick();
    flush = 1'b0;
    br_redirect = 1'b0;
    #1;

    // T6: flush won; sequential wrap; async reset mid-burst
    chk("t5_flush_wins", req_addr, 32'hFFFFFFF8);
    chk("t6_rv", 32'(req_valid), 32'd1);
    tick();
    chk("t6_wrap", req_addr, 32'h00000000);
    tick();
    chk("t6_addr8", req_addr, 32'h00000008);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rv", 32'(req_valid), 32'd0);
    chk("t6_rst_full", 32'(busy_full), 32'd0);
    chk("t6_rst_addr", req_addr, 32'hBFC00000);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_restart_rv", 32'(req_valid), 32'd1);
    chk("t6_restart_pc", req_addr, 32'hBFC00000);
    tick();
    chk("t6_restart_seq", req_addr, 32'hBFC00008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
